// File: rtl/gpu_pkg.sv
// Shared core types: scheduler core state and per-thread LSU state encodings.
package gpu_pkg;

    localparam int unsigned CORE_STATE_BITS = 3;
    localparam int unsigned LSU_STATE_BITS  = 2;

    typedef enum logic [CORE_STATE_BITS-1:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } core_state_t;

    typedef enum logic [LSU_STATE_BITS-1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: one LDR/STR per instruction against the data-memory
// controller over a valid/ready handshake; loaded byte is held on lsu_out.
module thread_lsu
    import gpu_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 mem_read_en,
    input  logic                 mem_write_en,
    input  logic [DATA_BITS-1:0] rs_data,
    input  logic [DATA_BITS-1:0] rt_data,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);

    lsu_state_t             r_state;
    lsu_state_t             w_next_state;
    logic                   r_is_read;
    logic                   r_read_valid;
    logic [ADDR_BITS-1:0]   r_read_address;
    logic                   r_write_valid;
    logic [ADDR_BITS-1:0]   r_write_address;
    logic [DATA_BITS-1:0]   r_write_data;
    logic [DATA_BITS-1:0]   r_lsu_out;

    core_state_t            w_core_state;
    logic                   w_start;
    logic                   w_read_done;
    logic                   w_write_done;

    assign w_core_state = core_state_t'(core_state);
    assign w_start      = (w_core_state == CORE_REQUEST) && (mem_read_en || mem_write_en);
    // Ready only counts while the matching request is outstanding.
    assign w_read_done  = r_read_valid && mem_read_ready;
    assign w_write_done = r_write_valid && mem_write_ready;

    // Next-state logic; a disabled thread freezes where it is.
    always_comb begin
        w_next_state = r_state;
        if (enable) begin
            case (r_state)
                LSU_IDLE:       if (w_start) w_next_state = LSU_REQUESTING;
                LSU_REQUESTING: w_next_state = LSU_WAITING;
                LSU_WAITING:    if (w_read_done || w_write_done) w_next_state = LSU_DONE;
                LSU_DONE:       if (w_core_state == CORE_UPDATE) w_next_state = LSU_IDLE;
                default:        w_next_state = LSU_IDLE;
            endcase
        end
    end

    // State register and request/response datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= LSU_IDLE;
            r_is_read       <= 1'b0;
            r_read_valid    <= 1'b0;
            r_read_address  <= '0;
            r_write_valid   <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
            r_lsu_out       <= '0;
        end else begin
            r_state <= w_next_state;
            if (enable) begin
                case (r_state)
                    LSU_IDLE: begin
                        // Load wins when both enables are set.
                        if (w_start) r_is_read <= mem_read_en;
                    end
                    LSU_REQUESTING: begin
                        if (r_is_read) begin
                            r_read_address <= ADDR_BITS'(rs_data);
                            r_read_valid   <= 1'b1;
                        end else begin
                            r_write_address <= ADDR_BITS'(rs_data);
                            r_write_data    <= rt_data;
                            r_write_valid   <= 1'b1;
                        end
                    end
                    LSU_WAITING: begin
                        if (w_read_done) begin
                            r_lsu_out    <= mem_read_data;
                            r_read_valid <= 1'b0;
                        end
                        if (w_write_done) begin
                            r_write_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_read_valid    = r_read_valid;
    assign mem_read_address  = r_read_address;
    assign mem_write_valid   = r_write_valid;
    assign mem_write_address = r_write_address;
    assign mem_write_data    = r_write_data;
    assign lsu_state         = r_state;
    assign lsu_out           = r_lsu_out;

endmodule

// File: tb/tb_thread_lsu.sv
// Bench for thread_lsu: directed LDR/STR sequences, transactions checked by a
// scoreboard monitor when the unit reaches DONE, plus direct control-path checks.
module tb_thread_lsu;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       mem_read_en;
    logic       mem_write_en;
    logic [7:0] rs_data;
    logic [7:0] rt_data;
    logic       mem_read_valid;
    logic [7:0] mem_read_address;
    logic       mem_read_ready;
    logic [7:0] mem_read_data;
    logic       mem_write_valid;
    logic [7:0] mem_write_address;
    logic [7:0] mem_write_data;
    logic       mem_write_ready;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;

    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_REQUEST = 3'd3;
    localparam logic [2:0] C_WAIT    = 3'd4;
    localparam logic [2:0] C_UPDATE  = 3'd6;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAITING = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .core_state        (core_state),
        .mem_read_en       (mem_read_en),
        .mem_write_en      (mem_write_en),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready),
        .lsu_state         (lsu_state),
        .lsu_out           (lsu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         rd_cyc;
        int         wr_cyc;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] lsu;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: tallies request activity and scores each transaction on DONE entry.
    task automatic monitor_loop();
        int         rd_cyc = 0;
        int         wr_cyc = 0;
        logic [7:0] rd_addr = '0;
        logic [7:0] wr_addr = '0;
        logic [7:0] wr_data = '0;
        logic [1:0] prev = S_IDLE;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_cyc = 0;
                wr_cyc = 0;
                prev   = S_IDLE;
            end else begin
                if (mem_read_valid) begin
                    rd_cyc++;
                    rd_addr = mem_read_address;
                end
                if (mem_write_valid) begin
                    wr_cyc++;
                    wr_addr = mem_write_address;
                    wr_data = mem_write_data;
                end
                if (lsu_state == S_DONE && prev != S_DONE) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("read_valid_cycles", 32'(rd_cyc), 32'(e.rd_cyc));
                        chk("write_valid_cycles", 32'(wr_cyc), 32'(e.wr_cyc));
                        if (e.rd_cyc > 0) chk("read_address", 32'(rd_addr), 32'(e.addr));
                        if (e.wr_cyc > 0) begin
                            chk("write_address", 32'(wr_addr), 32'(e.addr));
                            chk("write_data", 32'(wr_data), 32'(e.wdata));
                        end
                        chk("lsu_out", 32'(lsu_out), 32'(e.lsu));
                    end
                    rd_cyc = 0;
                    wr_cyc = 0;
                end
                prev = lsu_state;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction: REQUEST, WAIT with ready after 'delay' WAITING cycles, DONE hold, UPDATE.
    task automatic do_op(input logic rd, input logic wr, input logic [7:0] rs, input logic [7:0] rt,
                         input int delay, input logic [7:0] rdata, input exp_t e);
        int n;
        exp_q.push_back(e);
        core_state = C_REQUEST; mem_read_en = rd; mem_write_en = wr; rs_data = rs; rt_data = rt;
        tick();
        core_state = C_WAIT; mem_read_en = 1'b0; mem_write_en = 1'b0;
        tick();
        // Operands are sampled in REQUESTING only; disturb them afterwards.
        rs_data = 8'hEE; rt_data = 8'hEE;
        chk("waiting_state", 32'(lsu_state), 32'(S_WAITING));
        repeat (delay) tick();
        mem_read_ready = 1'b1; mem_write_ready = 1'b1; mem_read_data = rdata;
        n = 0;
        while (lsu_state != S_DONE && n < 20) begin
            tick();
            n++;
        end
        if (lsu_state != S_DONE) chk("done_timeout", 32'(lsu_state), 32'(S_DONE));
        // Ready still high in DONE must be ignored.
        mem_read_data = 8'h11;
        tick();
        chk("done_hold", 32'(lsu_state), 32'(S_DONE));
        chk("done_lsu_stable", 32'(lsu_out), 32'(e.lsu));
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        core_state = C_UPDATE;
        tick();
        chk("idle_after_update", 32'(lsu_state), 32'(S_IDLE));
        core_state = C_IDLE;
        tick();
    endtask

    initial begin
        exp_t e;
        checks = 0; failures = 0;
        reset = 1'b1; enable = 1'b1; core_state = C_IDLE;
        mem_read_en = 1'b0; mem_write_en = 1'b0; rs_data = '0; rt_data = '0;
        mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
        fork
            monitor_loop();
        join_none
        tick(); tick();
        chk("rst_state", 32'(lsu_state), 32'(S_IDLE));
        chk("rst_rvalid", 32'(mem_read_valid), 32'd0);
        chk("rst_wvalid", 32'(mem_write_valid), 32'd0);
        chk("rst_lsu_out", 32'(lsu_out), 32'd0);
        chk("rst_addr", 32'({mem_read_address, mem_write_address, mem_write_data}), 32'd0);
        reset = 1'b0;
        tick();

        // LDR 0x10, ready after two WAITING cycles
        e = '{rd_cyc: 3, wr_cyc: 0, addr: 8'h10, wdata: 8'h00, lsu: 8'h5A};
        do_op(1'b1, 1'b0, 8'h10, 8'h00, 2, 8'h5A, e);
        // STR 0x20 <- 0xC3, ready immediately; lsu_out keeps 0x5A
        e = '{rd_cyc: 0, wr_cyc: 1, addr: 8'h20, wdata: 8'hC3, lsu: 8'h5A};
        do_op(1'b0, 1'b1, 8'h20, 8'hC3, 0, 8'h99, e);
        // Both enables: load only
        e = '{rd_cyc: 1, wr_cyc: 0, addr: 8'h07, wdata: 8'h00, lsu: 8'h3C};
        do_op(1'b1, 1'b1, 8'h07, 8'h44, 0, 8'h3C, e);
        // Top address 0xFF
        e = '{rd_cyc: 2, wr_cyc: 0, addr: 8'hFF, wdata: 8'h00, lsu: 8'hA5};
        do_op(1'b1, 1'b0, 8'hFF, 8'h00, 1, 8'hA5, e);

        // Spurious ready in IDLE
        mem_read_ready = 1'b1; mem_write_ready = 1'b1; mem_read_data = 8'h99;
        repeat (3) begin
            tick();
            chk("spurious_state", 32'(lsu_state), 32'(S_IDLE));
            chk("spurious_lsu_out", 32'(lsu_out), 32'hA5);
        end
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;

        // Disabled thread ignores REQUEST
        enable = 1'b0; core_state = C_REQUEST; mem_read_en = 1'b1; rs_data = 8'h40;
        repeat (4) begin
            tick();
            chk("disabled_state", 32'(lsu_state), 32'(S_IDLE));
            chk("disabled_rvalid", 32'(mem_read_valid), 32'd0);
        end
        enable = 1'b1; core_state = C_IDLE; mem_read_en = 1'b0;
        tick();
        chk("reenable_state", 32'(lsu_state), 32'(S_IDLE));

        // Reset mid-handshake
        core_state = C_REQUEST; mem_read_en = 1'b1; rs_data = 8'h30;
        tick();
        core_state = C_WAIT; mem_read_en = 1'b0;
        tick();
        chk("pre_reset_rvalid", 32'(mem_read_valid), 32'd1);
        chk("pre_reset_raddr", 32'(mem_read_address), 32'h30);
        reset = 1'b1;
        tick();
        chk("mid_reset_rvalid", 32'(mem_read_valid), 32'd0);
        chk("mid_reset_state", 32'(lsu_state), 32'(S_IDLE));
        chk("mid_reset_lsu_out", 32'(lsu_out), 32'd0);
        reset = 1'b0; core_state = C_IDLE;
        tick(); tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
